position_writeback: RTL and testbench

- Per-cell motion-update writer for the MD engine.
- Runs after the force phase has finished accumulating velocities into the velocity cache.
- Reads each particle's position and velocity, integrates `p' = p + (v >>> DT_SHIFT)`, and writes `p'` into the opposite half of the double-buffered position cache. That half is the one the position ring reads next phase.
- One instance per cell, N_CELL instances side by side. The top level ANDs their CTL_DONE outputs.

---
 rtl/position_writeback.sv | 174 +++++++++++++++++
 tb/tb_position_writeback.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_writeback.sv
// -----------------------------------------------------------------------------
// position_writeback
//
// Per-cell motion-update writer. After the force phase has accumulated the
// velocities, this block walks the cell's position cache. For each particle it
// reads the position and the velocity, integrates p' = p + (v >>> DT_SHIFT) per
// axis, and writes p' into the opposite half of the double-buffered position
// cache. The position ring reads that half in the next phase. The walk stops
// at the first invalid entry, where an all-zero terminator is written, or when
// all DEPTH slots have been processed.
//
// Optional feature (compile-time macro WRAP_PERIODIC_EN): each updated axis is
// folded once into [0, BOX_MAX). When the macro is undefined the sum is a plain
// 32-bit wrapping add.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-low reset
//   CTL_READY         level start request from the phase controller
//   CTL_DOUBLE_BUFFER read-half select, latched at start of run
//                     (0: read 0..DEPTH-1, write DEPTH..2*DEPTH-1; 1: reverse)
//   CTL_DONE          high while the cell's writeback is complete
//   p_raddr/r_p_cache position cache read port (1-cycle latency)
//   v_raddr/r_v_cache velocity cache read port (1-cycle latency)
//   p_waddr/w_p_cache position cache write port, p_wr_en one-cycle strobe
//   count             valid particles written in the last run
// Entry format: [96]=valid, [95:64]=z, [63:32]=y, [31:0]=x (signed 32-bit).
// -----------------------------------------------------------------------------
module position_writeback #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned DT_SHIFT = 4,
  parameter logic [31:0] BOX_MAX  = 32'h0010_0000,
  parameter int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CTL_READY,
  input  logic          CTL_DOUBLE_BUFFER,
  output logic          CTL_DONE,
  output logic [31:0]   p_raddr,
  input  logic [96:0]   r_p_cache,
  output logic [31:0]   v_raddr,
  input  logic [96:0]   r_v_cache,
  output logic [31:0]   p_waddr,
  output logic [96:0]   w_p_cache,
  output logic          p_wr_en,
  output logic [CW-1:0] count
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam logic [31:0] HALF = 32'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  // Elaboration-time sanity checks on the configuration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("position_writeback: DEPTH must be a power of two >= 2");
  end
  if (BOX_MAX[31] || (BOX_MAX == '0)) begin : g_bad_box
    $error("position_writeback: BOX_MAX must be a positive signed value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_TERM,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          db_q;      // buffer select captured at start of run
  logic [95:0]   sum_q;     // updated {z, y, x} waiting for its WRITE cycle
  logic [CW-1:0] cnt_q;

  logic [31:0]   idx_ext;
  logic [31:0]   rbase;
  logic [31:0]   wbase;

  // Velocity valid bit carries no meaning for the update.
  logic          unused_vvalid;
  assign unused_vvalid = r_v_cache[96];

  assign idx_ext = 32'(idx);
  assign rbase   = db_q ? HALF  : '0;
  assign wbase   = db_q ? '0    : HALF;
  assign count   = cnt_q;

  function automatic logic [31:0] axis_update(input logic [31:0] p,
                                              input logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(p) + ($signed(v) >>> DT_SHIFT);
`ifdef WRAP_PERIODIC_EN
    // Velocities are bounded below BOX_MAX, so one fold lands in range.
    if (s >= $signed(BOX_MAX)) s = s - $signed(BOX_MAX);
    if (s < 0)                 s = s + $signed(BOX_MAX);
`endif
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      db_q  <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (CTL_READY) begin
            idx   <= '0;
            cnt_q <= '0;
            db_q  <= CTL_DOUBLE_BUFFER;
          end
        end
        S_WAIT: begin
          if (r_p_cache[96]) begin
            sum_q <= {axis_update(r_p_cache[95:64], r_v_cache[95:64]),
                      axis_update(r_p_cache[63:32], r_v_cache[63:32]),
                      axis_update(r_p_cache[31:0],  r_v_cache[31:0])};
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + 1'b1;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    CTL_DONE  = 1'b0;
    p_raddr   = '0;
    v_raddr   = '0;
    p_waddr   = '0;
    w_p_cache = '0;
    p_wr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (CTL_READY) state_nx = S_READ;
      end
      S_READ: begin
        p_raddr  = rbase + idx_ext;
        v_raddr  = idx_ext;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        state_nx = r_p_cache[96] ? S_WRITE : S_TERM;
      end
      S_WRITE: begin
        p_waddr   = wbase + idx_ext;
        w_p_cache = {1'b1, sum_q};
        p_wr_en   = 1'b1;
        state_nx  = (idx == LAST) ? S_DONE : S_READ;
      end
      S_TERM: begin
        p_waddr  = wbase + idx_ext;
        p_wr_en  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        CTL_DONE = 1'b1;
        if (!CTL_READY) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_position_writeback.sv
// -----------------------------------------------------------------------------
// tb_position_writeback
//
// Bench for position_writeback. Position and velocity caches are plain arrays
// with a 1-cycle read latency. For every run a reference walk over the cache
// contents lists the writes that must appear, together with the count and the
// cycle on which CTL_DONE must rise. A negedge monitor checks every write strobe
// against that list. Selected results are also pinned to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_position_writeback;

  localparam int unsigned DEPTH    = 256;
  localparam int unsigned DT_SHIFT = 4;
  localparam logic [31:0] BOX_MAX  = 32'h0010_0000;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int unsigned AW       = $clog2(2 * DEPTH);

  logic          clk;
  logic          reset;
  logic          CTL_READY;
  logic          CTL_DOUBLE_BUFFER;
  logic          CTL_DONE;
  logic [31:0]   p_raddr;
  logic [96:0]   r_p_cache;
  logic [31:0]   v_raddr;
  logic [96:0]   r_v_cache;
  logic [31:0]   p_waddr;
  logic [96:0]   w_p_cache;
  logic          p_wr_en;
  logic [CW-1:0] count;

  position_writeback #(
    .DEPTH   (DEPTH),
    .DT_SHIFT(DT_SHIFT),
    .BOX_MAX (BOX_MAX),
    .CW      (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .CTL_READY        (CTL_READY),
    .CTL_DOUBLE_BUFFER(CTL_DOUBLE_BUFFER),
    .CTL_DONE         (CTL_DONE),
    .p_raddr          (p_raddr),
    .r_p_cache        (r_p_cache),
    .v_raddr          (v_raddr),
    .r_v_cache        (r_v_cache),
    .p_waddr          (p_waddr),
    .w_p_cache        (w_p_cache),
    .p_wr_en          (p_wr_en),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [96:0] pmem [0:2*DEPTH-1];
  logic [96:0] vmem [0:DEPTH-1];

  always @(posedge clk) begin
    r_p_cache <= (p_raddr < 32'(2 * DEPTH)) ? pmem[p_raddr[AW-1:0]] : '0;
    r_v_cache <= (v_raddr < 32'(DEPTH))     ? vmem[v_raddr[AW-2:0]] : '0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [96:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wlog_addr[$];
  logic [96:0] wlog_data[$];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [96:0] act,
                              input logic [96:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (reset && p_wr_en) begin
      wr_t e;
      wlog_addr.push_back(p_waddr);
      wlog_data.push_back(w_p_cache);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: got write addr %h data %h, expected no write",
                 p_waddr, w_p_cache);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 97'(p_waddr), 97'(e.addr));
        chk("wr_data", w_p_cache, e.data);
      end
    end
  end

  function automatic logic [96:0] mk(input bit vld, input logic [31:0] x,
                                     input logic [31:0] y, input logic [31:0] z);
    return {vld, z, y, x};
  endfunction

  // Reference per-axis update: floor division by 2^DT_SHIFT, modulo-2^32 sum.
  function automatic logic [31:0] axis_model(input logic [31:0] p,
                                             input logic [31:0] v);
    longint d, vv, q, s;
    logic signed [31:0] r;
    d  = longint'(1) << DT_SHIFT;
    vv = longint'($signed(v));
    q  = (vv - (((vv % d) + d) % d)) / d;
    s  = longint'($signed(p)) + q;
    r  = s[31:0];
`ifdef WRAP_PERIODIC_EN
    if (r >= $signed(BOX_MAX)) r = r - $signed(BOX_MAX);
    if (r < 0)                 r = r + $signed(BOX_MAX);
`endif
    return r;
  endfunction

  task automatic build_expected(input bit db, output int n);
    int unsigned rb, wb;
    logic [96:0] p, v;
    exp_q.delete();
    n  = 0;
    rb = db ? DEPTH : 0;
    wb = db ? 0 : DEPTH;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      p = pmem[rb + i];
      v = vmem[i];
      if (!p[96]) begin
        exp_q.push_back('{addr: 32'(wb + i), data: '0});
        break;
      end
      exp_q.push_back('{addr: 32'(wb + i),
                        data: {1'b1, axis_model(p[95:64], v[95:64]),
                               axis_model(p[63:32], v[63:32]),
                               axis_model(p[31:0], v[31:0])}});
      n++;
    end
  endtask

  task automatic clear_mem();
    for (int unsigned i = 0; i < 2 * DEPTH; i++) pmem[i] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) vmem[i] = '0;
  endtask

  task automatic chk_log(input string nm, input int k, input logic [31:0] a,
                         input logic [96:0] d);
    if (k >= wlog_addr.size()) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: got %0d writes, required entry %0d", nm, wlog_addr.size(), k);
    end else begin
      chk({nm, "_addr"}, 97'(wlog_addr[k]), 97'(a));
      chk({nm, "_data"}, wlog_data[k], d);
    end
  endtask

  // One complete run: start, wait for CTL_DONE, check latency/count, then the
  // DONE hold and release handshake.
  task automatic run(input bit db, input bit toggle, input string tag);
    int n, cyc, lim, exp_lat;
    bit done;
    build_expected(db, n);
    wlog_addr.delete();
    wlog_data.delete();
    exp_lat = (n == DEPTH) ? 3 * DEPTH + 1 : 3 * n + 4;
    lim     = 3 * DEPTH + 20;
    @(negedge clk);
    CTL_DOUBLE_BUFFER = db;
    CTL_READY         = 1'b1;
    @(posedge clk);
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc <= lim) begin
      #1;
      if (CTL_DONE) begin
        done = 1'b1;
      end else begin
        if (toggle && cyc == 3) begin
          #1;
          CTL_READY         = 1'b0;
          CTL_DOUBLE_BUFFER = !db;
        end
        if (toggle && cyc == 6) begin
          #1;
          CTL_READY = 1'b1;
        end
        @(posedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s_timeout: got no CTL_DONE in %0d cycles, required at %0d",
               tag, lim, exp_lat);
    end else begin
      chk({tag, "_done_latency"}, 97'(cyc), 97'(exp_lat));
    end
    chk({tag, "_count"}, 97'(count), 97'(n));
    chk({tag, "_pending_writes"}, 97'(exp_q.size()), 97'(0));
    @(posedge clk);
    #1;
    chk({tag, "_done_hold"}, 97'(CTL_DONE), 97'(1));
    @(negedge clk);
    CTL_READY = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 97'(CTL_DONE), 97'(0));
    CTL_DOUBLE_BUFFER = 1'b0;
  endtask

  task automatic load_basic(input int unsigned base);
    pmem[base + 0] = mk(1'b1, 32'h100, 32'h10, 32'h0);
    pmem[base + 1] = mk(1'b1, 32'h200, 32'h10, 32'h0);
    pmem[base + 2] = mk(1'b1, 32'h300, 32'h10, 32'h0);
    pmem[base + 3] = '0;
    pmem[base + 4] = mk(1'b1, 32'h777, 32'h1, 32'h1);
    vmem[0] = mk(1'b1, 32'h40,  -32'sh11, 32'h35);
    vmem[1] = mk(1'b0, -32'sh40, -32'sh11, 32'h35);
    vmem[2] = mk(1'b1, 32'h0,   -32'sh11, 32'h35);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int n_dummy;
    reset             = 1'b0;
    CTL_READY         = 1'b0;
    CTL_DOUBLE_BUFFER = 1'b0;
    clear_mem();
    #12;
    chk("rst_done",   97'(CTL_DONE),  97'(0));
    chk("rst_wr_en",  97'(p_wr_en),   97'(0));
    chk("rst_waddr",  97'(p_waddr),   97'(0));
    chk("rst_raddr",  97'(p_raddr),   97'(0));
    chk("rst_vaddr",  97'(v_raddr),   97'(0));
    chk("rst_wdata",  w_p_cache,      97'(0));
    chk("rst_count",  97'(count),     97'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Three valid particles, terminator at slot 3, read low half.
    clear_mem();
    load_basic(0);
    run(1'b0, 1'b0, "basic");
    chk_log("basic_w0", 0, 32'(DEPTH + 0), {1'b1, 32'h3, 32'hE, 32'h104});
    chk_log("basic_w1", 1, 32'(DEPTH + 1), {1'b1, 32'h3, 32'hE, 32'h1FC});
    chk_log("basic_w2", 2, 32'(DEPTH + 2), {1'b1, 32'h3, 32'hE, 32'h300});
    chk_log("basic_term", 3, 32'(DEPTH + 3), '0);
    chk("basic_nwrites", 97'(wlog_addr.size()), 97'(4));

    // Same data in the high half, low half holds decoys; select flips mid-run.
    clear_mem();
    load_basic(DEPTH);
    for (int unsigned i = 0; i < 6; i++) pmem[i] = mk(1'b1, 32'h5000 + i, 32'h0, 32'h0);
    run(1'b1, 1'b1, "swap");
    chk_log("swap_w0", 0, 32'h0, {1'b1, 32'h3, 32'hE, 32'h104});
    chk_log("swap_w1", 1, 32'h1, {1'b1, 32'h3, 32'hE, 32'h1FC});
    chk_log("swap_w2", 2, 32'h2, {1'b1, 32'h3, 32'hE, 32'h300});
    chk_log("swap_term", 3, 32'h3, '0);

    // Empty cell: slot 0 invalid, later slots valid but never reached.
    clear_mem();
    pmem[1] = mk(1'b1, 32'h42, 32'h0, 32'h0);
    run(1'b0, 1'b0, "empty");
    chk_log("empty_term", 0, 32'(DEPTH), '0);
    chk("empty_nwrites", 97'(wlog_addr.size()), 97'(1));

    // Periodic boundary case.
    clear_mem();
    pmem[0] = mk(1'b1, BOX_MAX - 32'h1, 32'h0, 32'h0);
    vmem[0] = mk(1'b0, 32'h20, -32'sh20, 32'h0);
    run(1'b0, 1'b0, "wrap");
`ifdef WRAP_PERIODIC_EN
    chk_log("wrap_w0", 0, 32'(DEPTH), {1'b1, 32'h0, BOX_MAX - 32'h2, 32'h1});
`else
    chk_log("wrap_w0", 0, 32'(DEPTH), {1'b1, 32'h0, 32'hFFFF_FFFE, BOX_MAX + 32'h1});
`endif

    // Full buffer with random contents: no terminator.
    clear_mem();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pmem[i] = {1'b1, 32'($urandom), 32'($urandom), 32'($urandom)};
      vmem[i] = {1'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    end
    run(1'b0, 1'b0, "full");
    chk("full_nwrites", 97'(wlog_addr.size()), 97'(DEPTH));

    // Asynchronous reset while a write strobe is high.
    build_expected(1'b0, n_dummy);
    wlog_addr.delete();
    wlog_data.delete();
    @(negedge clk);
    CTL_READY = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (p_wr_en && wlog_addr.size() >= 1) break;
    end
    chk("rstmid_pre_wr_en", 97'(p_wr_en), 97'(1));
    chk("rstmid_pre_count", 97'(count), 97'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_wr_en", 97'(p_wr_en),  97'(0));
    chk("rstmid_done",  97'(CTL_DONE), 97'(0));
    chk("rstmid_count", 97'(count),    97'(0));
    chk("rstmid_waddr", 97'(p_waddr),  97'(0));
    CTL_READY = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_idle_done",  97'(CTL_DONE), 97'(0));
    chk("rstmid_idle_raddr", 97'(p_raddr),  97'(0));
    chk("rstmid_idle_count", 97'(count),    97'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
